// File: rtl/descrypt_core_dispatcher.sv
// descrypt_core_dispatcher: round-robin batch scheduler from the input FIFO to the descrypt cores; DISPATCH_STATS_EN adds batch/stall counters.
// Latency: 1 cycle FIFO head to core bus, plus a 1-cycle grant decision before each batch.
// Backpressure: pops only while streaming and the FIFO is non-empty; waits in SEL until some core is eligible.
module descrypt_core_dispatcher #(
  parameter int N_CORES       = 4,
  parameter int DIN_WIDTH     = 8,
  parameter int READY_HOLDOFF = 4,
  parameter int MAX_WORDS     = 16
) (
  input  logic                 CORE_CLK,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] src_din,
  input  logic [2:0]           src_addr,
  input  logic                 src_last,
  input  logic                 src_empty,
  output logic                 src_rd_en,
  output logic [DIN_WIDTH-1:0] dout,
  output logic [2:0]           addr_out,
  output logic [N_CORES-1:0]   wr_en,
  input  logic [N_CORES-1:0]   crypt_ready,
  input  logic [N_CORES-1:0]   core_idle,
  input  logic [N_CORES-1:0]   err_core,
  output logic [N_CORES-1:0]   err_mask,
  output logic                 all_dead,
  output logic                 overrun,
  output logic                 all_idle
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]          batch_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int IW  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int WCW = $clog2(MAX_WORDS + 1);

  typedef enum logic {SEL, STREAM} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, grant, grant_nxt;
  logic               grant_vld;
  logic [WCW-1:0]     word_cnt;
  logic [3:0]         holdoff [N_CORES];
  logic [N_CORES-1:0] hold_zero, eligible;
  logic               pop, word_limit, batch_end, sel_go;

  always_comb begin
    for (int i = 0; i < N_CORES; i++) hold_zero[i] = (holdoff[i] == 4'd0);
  end

  // err_core is folded in directly so a core erroring on its grant cycle is skipped
  assign eligible = crypt_ready & ~(err_mask | err_core) & hold_zero;

  // Scan downward so the last hit is the first eligible core above ptr
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    grant_vld = 1'b0;
    grant_nxt = ptr;
    idx       = 0;
    cand      = '0;
    for (int k = N_CORES; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      cand = IW'(idx);
      if (eligible[cand]) begin
        grant_vld = 1'b1;
        grant_nxt = cand;
      end
    end
  end

  assign pop        = (state == STREAM) & ~src_empty;
  assign word_limit = (word_cnt == WCW'(MAX_WORDS - 1));
  assign batch_end  = pop & (src_last | word_limit);
  assign sel_go     = (state == SEL) & ~src_empty & grant_vld;

  always_ff @(posedge CORE_CLK) begin
    if (rst) state <= SEL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    src_rd_en = 1'b0;
    case (state)
      SEL:     if (sel_go) state_nxt = STREAM;
      STREAM: begin
        src_rd_en = ~src_empty;
        if (batch_end) state_nxt = SEL;
      end
      default: state_nxt = SEL;
    endcase
  end

  always_ff @(posedge CORE_CLK) begin
    if (rst) begin
      ptr      <= IW'(N_CORES - 1);
      grant    <= '0;
      word_cnt <= '0;
      dout     <= '0;
      addr_out <= '0;
      wr_en    <= '0;
      err_mask <= '0;
      all_dead <= 1'b0;
      overrun  <= 1'b0;
      all_idle <= 1'b0;
      for (int i = 0; i < N_CORES; i++) holdoff[i] <= 4'd0;
    end else begin
      wr_en    <= '0;
      err_mask <= err_mask | err_core;
      all_dead <= &err_mask;
      all_idle <= (state == SEL) & src_empty & (&(core_idle | err_mask)) & (&hold_zero);
      for (int i = 0; i < N_CORES; i++) begin
        if (!hold_zero[i]) holdoff[i] <= holdoff[i] - 4'd1;
      end
      if (sel_go) begin
        grant    <= grant_nxt;
        ptr      <= grant_nxt;
        word_cnt <= '0;
      end
      if (pop) begin
        dout     <= src_din;
        addr_out <= src_addr;
        wr_en    <= N_CORES'(1) << grant;
        word_cnt <= word_cnt + 1'b1;
        if (word_limit & ~src_last) overrun <= 1'b1;
        // a fresh load wins over the decrement above
        if (batch_end) holdoff[grant] <= 4'(READY_HOLDOFF);
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge CORE_CLK) begin
    if (rst) begin
      batch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (batch_end) batch_cnt <= batch_cnt + 32'd1;
      if ((state == SEL) & ~src_empty & ~grant_vld & (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
